// File: rtl/uart_rx.sv
// UART receiver: 16x oversampling, 5..8 data bits, optional parity, 1 or 2 stop bits.
// Define UART_RX_FIFO_EN to use a 4-entry output FIFO instead of a single holding register.
module uart_rx (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    input  logic [15:0] divisor,
    input  logic [1:0]  data_bits,
    input  logic        stop2,
    input  logic        parity_en,
    input  logic        even_par,
    output logic [7:0]  rx_data,
    output logic        rx_perr,
    output logic        rx_ferr,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        overrun,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
    } state_t;

    state_t      r_state;
    logic        r_sync1, r_sync2, r_rxd_d;
    logic [15:0] r_tick_cnt;
    logic [3:0]  r_os;
    logic [2:0]  r_bit_cnt;
    logic [2:0]  r_nbits_m1;
    logic        r_stop2, r_par_en, r_even;
    logic [7:0]  r_shift;
    logic        r_perr, r_ferr1;
    logic        r_overrun;

    logic        w_fall, w_start, w_tick, w_sample, w_done, w_done_ferr;

    assign w_fall      = r_rxd_d & ~r_sync2;
    assign w_start     = (r_state == S_IDLE) & w_fall;
    assign w_tick      = (r_tick_cnt == divisor);
    assign w_sample    = w_tick & (r_os == 4'd7) & (r_state != S_IDLE);
    assign w_done      = w_sample & (((r_state == S_STOP1) & ~r_stop2) | (r_state == S_STOP2));
    assign w_done_ferr = ~r_sync2 | r_ferr1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_rxd_d <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
            r_rxd_d <= r_sync2;
        end
    end

    // Restarting the tick counter on the start edge aligns oversample phase to the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_tick_cnt <= 16'd0;
        else if (w_start || w_tick)
            r_tick_cnt <= 16'd0;
        else
            r_tick_cnt <= r_tick_cnt + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_os       <= 4'd0;
            r_bit_cnt  <= 3'd0;
            r_nbits_m1 <= 3'd0;
            r_stop2    <= 1'b0;
            r_par_en   <= 1'b0;
            r_even     <= 1'b0;
            r_shift    <= 8'd0;
            r_perr     <= 1'b0;
            r_ferr1    <= 1'b0;
        end else begin
            if (r_state != S_IDLE && w_tick)
                r_os <= r_os + 4'd1;
            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state    <= S_START;
                        r_os       <= 4'd0;
                        r_bit_cnt  <= 3'd0;
                        r_nbits_m1 <= {1'b0, data_bits} + 3'd4;
                        r_stop2    <= stop2;
                        r_par_en   <= parity_en;
                        r_even     <= even_par;
                        r_shift    <= 8'd0;
                        r_perr     <= 1'b0;
                        r_ferr1    <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_sample)
                        r_state <= r_sync2 ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    if (w_sample) begin
                        r_shift[r_bit_cnt] <= r_sync2;
                        if (r_bit_cnt == r_nbits_m1) begin
                            r_bit_cnt <= 3'd0;
                            r_state   <= r_par_en ? S_PARITY : S_STOP1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                S_PARITY: begin
                    // Unused upper shift bits are zero, so the full-width XOR is the data parity.
                    if (w_sample) begin
                        r_perr  <= r_sync2 ^ (^r_shift) ^ ~r_even;
                        r_state <= S_STOP1;
                    end
                end
                S_STOP1: begin
                    if (w_sample) begin
                        r_ferr1 <= ~r_sync2;
                        r_state <= r_stop2 ? S_STOP2 : S_IDLE;
                    end
                end
                S_STOP2: begin
                    if (w_sample)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign overrun = r_overrun;

`ifdef UART_RX_FIFO_EN
    logic [9:0] r_mem [4];
    logic [1:0] r_wptr, r_rptr;
    logic [2:0] r_count;
    logic       w_full, w_pop, w_push;
    logic [9:0] w_head;

    assign w_full = (r_count == 3'd4);
    assign w_pop  = (r_count != 3'd0) & rx_ready;
    assign w_push = w_done & (~w_full | w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr    <= 2'd0;
            r_rptr    <= 2'd0;
            r_count   <= 3'd0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 2'd1;
            if (w_pop)
                r_rptr <= r_rptr + 2'd1;
            r_count   <= r_count + {2'b00, w_push} - {2'b00, w_pop};
            r_overrun <= w_done & ~w_push;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= {r_shift, r_perr, w_done_ferr};
    end

    assign rx_valid = (r_count != 3'd0);
    assign w_head   = rx_valid ? r_mem[r_rptr] : 10'd0;
    assign {rx_data, rx_perr, rx_ferr} = w_head;
`else
    logic       r_valid;
    logic [7:0] r_data;
    logic       r_perr_o, r_ferr_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_data    <= 8'd0;
            r_perr_o  <= 1'b0;
            r_ferr_o  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_done && (!r_valid || rx_ready)) begin
                r_valid  <= 1'b1;
                r_data   <= r_shift;
                r_perr_o <= r_perr;
                r_ferr_o <= w_done_ferr;
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
            r_overrun <= w_done & r_valid & ~rx_ready;
        end
    end

    assign rx_valid = r_valid;
    assign rx_data  = r_data;
    assign rx_perr  = r_perr_o;
    assign rx_ferr  = r_ferr_o;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, randomized frames against a frame-level
// reference model, and hand sequences for glitch, overrun and mid-frame reset.
module tb_uart_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxd = 1'b1;
    logic [15:0] divisor = 16'd0;
    logic [1:0]  data_bits = 2'd3;
    logic        stop2 = 1'b0;
    logic        parity_en = 1'b0;
    logic        even_par = 1'b0;
    logic        rx_ready = 1'b1;
    logic [7:0]  rx_data;
    logic        rx_perr, rx_ferr, rx_valid, overrun, busy;

    uart_rx dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .divisor   (divisor),
        .data_bits (data_bits),
        .stop2     (stop2),
        .parity_en (parity_en),
        .even_par  (even_par),
        .rx_data   (rx_data),
        .rx_perr   (rx_perr),
        .rx_ferr   (rx_ferr),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [9:0] rq[$];
    int         vcyc = 0;
    int         ovr  = 0;

    // Monitor: records every accepted character, valid-high cycles and overrun pulses.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (rx_valid) vcyc++;
            if (rx_valid && rx_ready) rq.push_back({rx_data, rx_perr, rx_ferr});
            if (overrun) ovr++;
        end
    end

    typedef struct {
        int         div;
        int         nb;
        bit         pe;
        bit         ev;
        bit         two;
        logic [7:0] d;
        bit         pb;
        bit         s1;
        bit         s2v;
        logic [7:0] ed;
        bit         ep;
        bit         ef;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive_bit(input logic v, input int clks);
        rxd = v;
        repeat (clks) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input logic pe, input logic pb,
                              input logic s1, input logic two, input logic s2v);
        int bl;
        bl = 16 * (int'(divisor) + 1);
        drive_bit(1'b0, bl);
        for (int i = 0; i < nbits; i++) drive_bit(d[i], bl);
        if (pe) drive_bit(pb, bl);
        drive_bit(s1, bl);
        if (two) drive_bit(s2v, bl);
        drive_bit(1'b1, 2 * bl);
    endtask

    task automatic wait_chars(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (rq.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (rq.size() >= n) ok = 1'b1;
    endtask

    // Frame-level reference: what a receiver must report for the given line fields.
    function automatic logic [9:0] model(input logic [7:0] d, input int nbits, input bit pe,
                                         input bit ev, input bit pb, input bit s1,
                                         input bit two, input bit s2v);
        logic [7:0] mask;
        logic [7:0] dm;
        int         ones;
        bit         perr, ferr;
        mask = 8'((1 << nbits) - 1);
        dm   = d & mask;
        ones = $countones(dm);
        perr = pe && (ev ? (pb != (ones % 2 == 1)) : (pb == (ones % 2 == 1)));
        ferr = !s1 || (two && !s2v);
        return {dm, perr, ferr};
    endfunction

    task automatic apply_cfg(input int div, input int nb, input bit pe, input bit ev, input bit two);
        divisor   = 16'(div);
        data_bits = 2'(nb - 5);
        parity_en = pe;
        even_par  = ev;
        stop2     = two;
    endtask

`ifdef UART_RX_FIFO_EN
    localparam int EXP_HELD = 4;
    localparam int EXP_OVR  = 1;
`else
    localparam int EXP_HELD = 1;
    localparam int EXP_OVR  = 4;
`endif

    initial begin
        vec_t       tbl[8];
        int         base, v0, o0, cyc;
        bit         ok, saw_busy;
        logic [9:0] exp;

        tbl[0] = '{0, 8, 0, 0, 0, 8'hA5, 0, 1, 1, 8'hA5, 0, 0};
        tbl[1] = '{3, 7, 1, 1, 0, 8'h41, 1, 1, 1, 8'h41, 1, 0};
        tbl[2] = '{1, 8, 0, 0, 1, 8'h3C, 0, 1, 0, 8'h3C, 0, 1};
        tbl[3] = '{1, 8, 0, 0, 1, 8'h55, 0, 1, 1, 8'h55, 0, 0};
        tbl[4] = '{2, 5, 0, 0, 0, 8'hFF, 0, 1, 1, 8'h1F, 0, 0};
        tbl[5] = '{0, 6, 1, 0, 0, 8'h2A, 0, 1, 1, 8'h2A, 0, 0};
        tbl[6] = '{0, 8, 1, 0, 0, 8'h00, 0, 1, 1, 8'h00, 1, 0};
        tbl[7] = '{4, 8, 0, 0, 0, 8'h80, 0, 0, 1, 8'h80, 0, 1};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rx_data", 32'(rx_data), 32'h0);
        check("rst_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_rx_perr", 32'(rx_perr), 32'h0);
        check("rst_rx_ferr", 32'(rx_ferr), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // Vector table, consumer always ready
        for (int i = 0; i < 8; i++) begin
            apply_cfg(tbl[i].div, tbl[i].nb, tbl[i].pe, tbl[i].ev, tbl[i].two);
            base = rq.size();
            v0   = vcyc;
            send_frame(tbl[i].d, tbl[i].nb, tbl[i].pe, tbl[i].pb, tbl[i].s1, tbl[i].two, tbl[i].s2v);
            wait_chars(base + 1, 200, ok);
            check($sformatf("vec%0d_received", i), 32'(ok), 32'h1);
            check($sformatf("vec%0d_count", i), 32'(rq.size() - base), 32'h1);
            if (ok) begin
                check($sformatf("vec%0d_data", i), 32'(rq[base][9:2]), 32'(tbl[i].ed));
                check($sformatf("vec%0d_perr", i), 32'(rq[base][1]), 32'(tbl[i].ep));
                check($sformatf("vec%0d_ferr", i), 32'(rq[base][0]), 32'(tbl[i].ef));
            end
            check($sformatf("vec%0d_valid_cycles", i), 32'(vcyc - v0), 32'h1);
        end

        // Glitch on idle line
        apply_cfg(0, 8, 0, 0, 0);
        base     = rq.size();
        saw_busy = 1'b0;
        rxd      = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
            @(posedge clk);
            #1;
        end
        rxd = 1'b1;
        check("glitch_busy_rose", 32'(saw_busy), 32'h1);
        cyc = 0;
        @(negedge clk);
        while (busy && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        check("glitch_busy_cleared", 32'(busy), 32'h0);
        repeat (40) @(negedge clk);
        check("glitch_no_output", 32'(rq.size() - base), 32'h0);
        @(posedge clk);
        #1;

        // Randomized frames against the reference model
        for (int i = 0; i < 24; i++) begin
            int         div, nb;
            bit         pe, ev, two, pb, s1, s2v;
            logic [7:0] d;
            div = $urandom_range(0, 3);
            nb  = $urandom_range(5, 8);
            pe  = 1'($urandom_range(0, 1));
            ev  = 1'($urandom_range(0, 1));
            two = 1'($urandom_range(0, 1));
            pb  = 1'($urandom_range(0, 1));
            s1  = ($urandom_range(0, 3) != 0);
            s2v = ($urandom_range(0, 3) != 0);
            d   = 8'($urandom);
            exp = model(d, nb, pe, ev, pb, s1, two, s2v);
            apply_cfg(div, nb, pe, ev, two);
            base = rq.size();
            send_frame(d, nb, pe, pb, s1, two, s2v);
            wait_chars(base + 1, 200, ok);
            check($sformatf("rand%0d_received", i), 32'(ok), 32'h1);
            if (ok) check($sformatf("rand%0d_char", i), 32'(rq[base]), 32'(exp));
        end

        // Overrun: consumer stalled across five frames
        apply_cfg(0, 8, 0, 0, 0);
        rx_ready = 1'b0;
        base = rq.size();
        o0   = ovr;
        for (int k = 1; k <= 5; k++) send_frame(8'(k), 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("ovr_pulses", 32'(ovr - o0), 32'(EXP_OVR));
        check("ovr_nothing_accepted", 32'(rq.size() - base), 32'h0);
        check("ovr_valid_held", 32'(rx_valid), 32'h1);
        check("ovr_head_data", 32'(rx_data), 32'h01);
        @(posedge clk);
        #1 rx_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("ovr_drain_count", 32'(rq.size() - base), 32'(EXP_HELD));
        for (int j = 0; j < EXP_HELD; j++)
            if (rq.size() > base + j)
                check($sformatf("ovr_drain%0d", j), 32'(rq[base + j]), 32'({8'(j + 1), 2'b00}));
        check("ovr_drained_valid", 32'(rx_valid), 32'h0);
        @(posedge clk);
        #1;

        // Reset in the middle of the data bits of 0xFF, then a clean 0x12
        apply_cfg(1, 8, 0, 0, 0);
        base = rq.size();
        drive_bit(1'b0, 32);
        drive_bit(1'b1, 32);
        drive_bit(1'b1, 32);
        drive_bit(1'b1, 16);
        @(negedge clk);
        check("midrst_busy_before", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        check("midrst_busy_async", 32'(busy), 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        drive_bit(1'b1, 32 * 8);
        check("midrst_partial_dropped", 32'(rq.size() - base), 32'h0);
        send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_chars(base + 1, 200, ok);
        check("midrst_count", 32'(rq.size() - base), 32'h1);
        if (ok) check("midrst_char", 32'(rq[base]), 32'({8'h12, 2'b00}));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
